// File: rtl/mem_pkg.sv
// Shared size codes, FSM state encoding and lane-mask helper for the MEM-stage data memory.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_state_e;

  // Byte-enable mask for a store; size 2'b11 behaves as a full word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      MEM_SIZE_BYTE: mask = 4'b0001 << off;
      MEM_SIZE_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      default:       mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM/WB data-memory access bundle; master is the pipeline side, slave the memory stage.
interface mem_access_stage_if;

  logic        memReadMEM;
  logic        memWriteMEM;
  logic [1:0]  memSizeMEM;
  logic        memUnsignedMEM;
  logic [31:0] addrMEM;
  logic [31:0] writeDataMEM;
  logic [31:0] memReadDataMEM;
  logic        memStall;
  logic        memMisaligned;

  modport master (
    output memReadMEM, memWriteMEM, memSizeMEM, memUnsignedMEM, addrMEM, writeDataMEM,
    input  memReadDataMEM, memStall, memMisaligned
  );

  modport slave (
    input  memReadMEM, memWriteMEM, memSizeMEM, memUnsignedMEM, addrMEM, writeDataMEM,
    output memReadDataMEM, memStall, memMisaligned
  );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load lane select and sign/zero extension of a little-endian 32-bit word.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      MEM_SIZE_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      MEM_SIZE_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:       data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data memory with WAIT_CYCLES latency and pipeline stall.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_stage_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  logic [31:0]      mem_q [DEPTH_WORDS];
  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req;
  logic             rd_only;
  logic             misaligned;
  logic             stall;
  logic             complete;
  logic             wr_en;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;
  logic [31:0]      store_lanes;
  logic [31:0]      merged_word;
  logic [3:0]       byte_en;
  logic             unused_addr;

  assign req         = bus.memReadMEM | bus.memWriteMEM;
  assign rd_only     = bus.memReadMEM & ~bus.memWriteMEM;
  assign idx         = bus.addrMEM[IDX_W+1:2];
  assign off         = bus.addrMEM[1:0];
  assign unused_addr = ^bus.addrMEM[31:IDX_W+2];
  assign rd_word     = mem_q[idx];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = req & (((bus.memSizeMEM == MEM_SIZE_HALF) & off[0]) |
                             (bus.memSizeMEM[1] & (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  mem_load_align u_load_align (
    .word_i     (rd_word),
    .offset_i   (off),
    .size_i     (bus.memSizeMEM),
    .unsigned_i (bus.memUnsignedMEM),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall depends only on req and state, never on read data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (req) begin
          if (misaligned || (WAIT_CYCLES == 0)) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = MEM_ST_WAIT;
          end
        end
      end
      MEM_ST_WAIT: begin
        if (!req) begin
          state_d = MEM_ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          complete = 1'b1;
          state_d  = MEM_ST_IDLE;
          cnt_d    = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = MEM_ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.memStall       = rst_n & stall;
  assign bus.memMisaligned  = rst_n & complete & misaligned;
  assign bus.memReadDataMEM = (rst_n & complete & rd_only & ~misaligned) ? load_data : 32'h0;

  // Sub-word stores replicate the low byte/half so every lane sees it; the mask picks one.
  always_comb begin
    case (bus.memSizeMEM)
      MEM_SIZE_BYTE: store_lanes = {4{bus.writeDataMEM[7:0]}};
      MEM_SIZE_HALF: store_lanes = {2{bus.writeDataMEM[15:0]}};
      default:       store_lanes = bus.writeDataMEM;
    endcase
  end

  assign byte_en = lane_mask(bus.memSizeMEM, off);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? store_lanes[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end
  endgenerate

  assign wr_en = rst_n & complete & bus.memWriteMEM & ~misaligned;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage against a byte-addressed memory model.
module tb_mem_access_stage;

  localparam int WAIT  = 2;
  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic clk;
  logic rst_n;

  mem_access_stage_if bus ();

  mem_access_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  mdl [BYTES];
  logic        exp_stall;
  logic        exp_mis;
  logic [31:0] exp_rd;
  logic [31:0] last_rd;
  logic        last_mis;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %08h required %08h at %0t", name, got, want, $time);
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    bit en;
`ifdef MEM_ALIGN_CHECK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
  endfunction

  function automatic int lane_base(input logic [1:0] sz, input logic [31:0] a);
    int ab;
    int n;
    n  = size_bytes(sz);
    ab = int'(a % BYTES);
    return ab - (ab % n);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] v;
    int n;
    int base;
    n    = size_bytes(sz);
    base = lane_base(sz, a);
    v    = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mdl[base + k]) << (8 * k));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    int base;
    n    = size_bytes(sz);
    base = lane_base(sz, a);
    for (int k = 0; k < n; k++) mdl[base + k] = 8'(wd >> (8 * k));
  endtask

  always @(negedge clk) begin
    chk("stall", {31'b0, bus.memStall}, {31'b0, exp_stall});
    chk("rdata", bus.memReadDataMEM, exp_rd);
    chk("misaligned", {31'b0, bus.memMisaligned}, {31'b0, exp_mis});
  end

  task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.memReadMEM     = rd;
    bus.memWriteMEM    = wr;
    bus.memSizeMEM     = sz;
    bus.memUnsignedMEM = uns;
    bus.addrMEM        = a;
    bus.writeDataMEM   = wd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    exp_stall = 1'b0; exp_rd = 32'h0; exp_mis = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full access; returns at posedge+1 of the cycle after completion, ready for back-to-back.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    bit mis;
    drive(rd, wr, sz, uns, a, wd);
    mis = model_mis(sz, a);
    if (!mis) begin
      for (int i = 0; i < WAIT; i++) begin
        exp_stall = 1'b1; exp_rd = 32'h0; exp_mis = 1'b0;
        @(posedge clk); #1;
      end
    end
    exp_stall = 1'b0;
    exp_mis   = mis;
    exp_rd    = (rd && !wr && !mis) ? model_load(sz, uns, a) : 32'h0;
    @(negedge clk);
    last_rd  = bus.memReadDataMEM;
    last_mis = bus.memMisaligned;
    $display("txn rd=%0d wr=%0d size=%0d uns=%0d addr=%08h wdata=%08h rdata=%08h mis=%0d",
             rd, wr, sz, uns, a, wd, last_rd, last_mis);
    @(posedge clk);
    if (wr && !mis) model_store(sz, a, wd);
    #1;
  endtask

  // Request held for 'hold' cycles, then withdrawn before completion.
  task automatic flush(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
    drive(rd, wr, sz, 1'b0, a, wd);
    for (int i = 0; i < hold; i++) begin
      exp_stall = 1'b1; exp_rd = 32'h0; exp_mis = 1'b0;
      @(posedge clk); #1;
    end
    $display("txn flush rd=%0d wr=%0d addr=%08h after %0d cycles", rd, wr, a, hold);
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0;
    exp_stall = 1'b0; exp_rd = 32'h0; exp_mis = 1'b0;
    last_rd = 32'h0; last_mis = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_0x10", last_rd, 32'hDEADBEEF);

    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000080);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lb_0x11", last_rd, 32'hFFFFFF80);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("lbu_0x11", last_rd, 32'h00000080);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_after_sb", last_rd, 32'hDEAD80EF);

    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_0x12", last_rd, 32'h00001234);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_after_sh", last_rd, 32'h123480EF);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lh_0x10", last_rd, 32'hFFFF80EF);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("lhu_0x10", last_rd, 32'h000080EF);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h410, 32'h0);
    chk("lw_wrap_size3", last_rd, 32'h123480EF);
    idle(1);

    flush(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1);
    flush(1'b0, 1'b1, 2'b00, 32'h10, 32'h000000AA, 1);
    flush(1'b0, 1'b1, 2'b10, 32'h10, 32'h00000000, 2);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_after_flush", last_rd, 32'h123480EF);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    idle(1);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    exp_stall = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_stall = 1'b0; exp_rd = 32'h0; exp_mis = 1'b0;
    #1 chk("rst_mid_stall", {31'b0, bus.memStall}, 32'h0);
    @(posedge clk); #1;
    $display("txn reset during store addr=00000020");
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    idle(1);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lw_after_rst", last_rd, 32'h11223344);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h00000055);
`ifdef MEM_ALIGN_CHECK_EN
    chk("sw_0x22_mis", {31'b0, last_mis}, 32'h1);
`else
    chk("sw_0x22_mis", {31'b0, last_mis}, 32'h0);
`endif
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("lw_0x20_align", last_rd, 32'h11223344);
`else
    chk("lw_0x20_align", last_rd, 32'h00000055);
`endif

    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D);
    chk("rd_wr_both_rdata", last_rd, 32'h0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("lw_0x30", last_rd, 32'h0BADF00D);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data memory access unit. It sits between the EX/MEM pipeline register and the MEM/WB register, and drives memReadDataMEM into MEM/WB. It holds a word-organised data array and models a slow memory with WAIT_CYCLES of latency. While an access is in flight it raises memStall so hazard control freezes PC, IF/ID, ID/EX and EX/MEM and inserts a bubble into MEM/WB. It supports byte, halfword and word loads/stores, with sign or zero extension on loads.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the data array (power of two)
WAIT_CYCLES, 2, stall cycles per memory access; 0 means single-cycle access with no stall

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
memReadMEM  input  1  load request from EX/MEM
memWriteMEM  input  1  store request from EX/MEM
memSizeMEM  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
memUnsignedMEM  input  1  1 = zero-extend load, 0 = sign-extend load
addrMEM  input  32  byte address (ALU result)
writeDataMEM  input  32  store data; low byte/half used for sub-word stores
memReadDataMEM  output  32  extended load data, valid in the completion cycle
memStall  output  1  1 = access in flight, hold upstream stages
memMisaligned  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- req = memReadMEM | memWriteMEM. If both are high, the store wins and read data is 0.
- FSM states: IDLE, WAIT. Counter cnt is ceil(log2(WAIT_CYCLES+1)) bits wide.
- Reset (async, rst_n low): state=IDLE, cnt=0. Outputs: memStall=0, memReadDataMEM=0, memMisaligned=0. Array contents are not cleared.
- IDLE, req, WAIT_CYCLES==0: completion cycle. memStall=0, stay in IDLE.
- IDLE, req, WAIT_CYCLES>0: memStall=1, cnt<=1, go to WAIT.
- WAIT, cnt<WAIT_CYCLES: memStall=1, cnt<=cnt+1.
- WAIT, cnt==WAIT_CYCLES: completion cycle. memStall=0, cnt<=0, go to IDLE.
- Result: exactly WAIT_CYCLES stall cycles per access. Back-to-back accesses restart from IDLE with no gap cycle.
- Completion cycle, load: memReadDataMEM = extended array data, combinational from the array. MEM/WB captures it at the closing edge.
- Completion cycle, store: array updated at the closing edge. Nothing is written in stall cycles.
- memReadDataMEM = 0 in any non-completion cycle and when no load is active.
- Flush: req dropping while in WAIT aborts the access. Go to IDLE, cnt=0, no write.
- rst_n asserted mid-access: access aborted, no write.
- Indexing: word index = addrMEM[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo array size.
- Lanes are little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Byte loads extend bit 7; half loads extend bit 15; word loads are passed through.
- Sub-word stores use read-modify-write of the addressed word. Only the selected lane(s) change.
- memStall depends combinationally on req and state. It must not depend on memReadDataMEM (no combinational loop through hazard logic).

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, completes immediately in IDLE with no stall. In that cycle memMisaligned=1, any store is suppressed, and memReadDataMEM=0.
- Not defined: memMisaligned is tied 0. Alignment bits are ignored: half uses addr[1], word uses addr[1:0]=00. The access proceeds normally.

Decomposition:
- Shared package mem_pkg holds:
  - size codes MEM_SIZE_BYTE=2'b00, MEM_SIZE_HALF=2'b01, MEM_SIZE_WORD=2'b10
  - FSM state encodings MEM_ST_IDLE, MEM_ST_WAIT
- One natural sub-module: mem_load_align. It is purely combinational: word, byte offset, size and unsigned flag in, extended 32-bit load data out. It is reused by any future cache.

Test Plan:
- Reset then WAIT_CYCLES=2, store word 0xDEADBEEF at 0x10, then load word 0x10 -> memStall high 2 cycles each; load completion cycle shows memReadDataMEM=0xDEADBEEF.
- Store byte 0x80 at 0x11, then lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0xDEAD80EF.
- Store half 0x1234 at 0x12, then lh 0x12 -> 0x00001234; lw 0x10 -> 0x123480EF.
- Load at 0x10 with req dropped in the 2nd stall cycle, then a store with req dropped mid-WAIT -> FSM returns to IDLE, no array change, memStall low next cycle.
- rst_n pulsed low during WAIT of a store to 0x20 -> memStall=0 immediately; a later lw 0x20 returns the prior contents.
- With MEM_ALIGN_CHECK_EN: sw 0x55 to 0x22 -> memMisaligned=1 with no stall, then lw 0x20 unchanged. Without the macro: same stimulus writes 0x00000055 to word 0x20.
